regfile_write_arbiter: RTL and testbench

- Shares the single write port of the 16-entry register bank between NUM_REQ writeback sources, e.g. ALU writeback, load unit and moves.
- Round-robin arbitration with a valid/ready handshake per requester; the winner drives one registered write per cycle.
- Keeps a busy-bit scoreboard of destination registers that are reserved at issue and still awaiting writeback. Issue logic uses it to detect read-after-write hazards.

---
 rtl/regfile_write_arbiter_if.sv | 28 ++
 rtl/regfile_write_arbiter.sv | 126 ++++++++++++
 tb/tb_regfile_write_arbiter.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/regfile_write_arbiter_if.sv
// Write-request bus between the writeback sources and the register-bank
// write arbiter. Requester i uses the slice i of each packed vector.
interface regfile_write_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 4
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;

  // Writeback sources drive requests and observe the grant.
  modport master (
    output req_valid,
    output req_addr,
    output req_data,
    input  req_ready
  );

  // The arbiter consumes requests and returns the one-hot grant.
  modport slave (
    input  req_valid,
    input  req_addr,
    input  req_data,
    output req_ready
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter for the single register-bank write port, plus the
// busy-bit scoreboard that issue logic uses to detect RAW hazards.
// Writes are presented to the bank one cycle after their handshake.
// r0 is hardwired to zero: writes to it are consumed but never enabled,
// and it can never be marked busy.
module regfile_write_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 4
) (
  input  logic                   clock,
  input  logic                   reset_n,
  regfile_write_arbiter_if.slave bus,
  input  logic                   rsv_valid,
  input  logic [ADDR_W-1:0]      rsv_addr,
  output logic                   rsv_ready,
  input  logic [ADDR_W-1:0]      chk_addr1,
  input  logic [ADDR_W-1:0]      chk_addr2,
  output logic                   chk_busy1,
  output logic                   chk_busy2,
  output logic [2**ADDR_W-1:0]   busy_mask,
  output logic                   RegWrite,
  output logic [ADDR_W-1:0]      WriteRegister,
  output logic [DATA_W-1:0]      WriteData
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]       rr_ptr;
  logic [PTR_W-1:0]       rr_ptr_nxt;
  logic [PTR_W-1:0]       win_idx;
  logic                   win_found;
  logic [ADDR_W-1:0]      win_addr;
  logic [DATA_W-1:0]      win_data;
  logic                   xfer;
  logic                   rsv_fire;
  logic [2**ADDR_W-1:0]   busy_nxt;

  // Requester index base+offset, wrapped into 0..NUM_REQ-1.
  function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] base,
                                                input int offset);
    int sum;
    sum = int'(base) + offset;
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    return PTR_W'(sum);
  endfunction

  // Priority search starting at rr_ptr; only req_valid feeds the grant.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!win_found && bus.req_valid[wrap_idx(rr_ptr, k)]) begin
        win_found = 1'b1;
        win_idx   = wrap_idx(rr_ptr, k);
      end
    end
  end

  // One-hot grant back to the requesters, zero when nobody asks.
  always_comb begin
    bus.req_ready = '0;
    if (win_found) bus.req_ready[win_idx] = 1'b1;
  end

  // Winner's payload and the pointer that follows it.
  always_comb begin
    win_addr   = bus.req_addr[int'(win_idx)*ADDR_W +: ADDR_W];
    win_data   = bus.req_data[int'(win_idx)*DATA_W +: DATA_W];
    rr_ptr_nxt = (int'(win_idx) == NUM_REQ - 1) ? '0 : win_idx + 1'b1;
  end

  // A granted requester is by construction valid, so a winner means a transfer.
  assign xfer = win_found;

  // Round-robin pointer advances past the winner on every transfer.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr <= '0;
    end else if (xfer) begin
      rr_ptr <= rr_ptr_nxt;
    end
  end

  // Registered bank write; address and data hold when there is no transfer.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      RegWrite      <= 1'b0;
      WriteRegister <= '0;
      WriteData     <= '0;
    end else begin
      RegWrite <= xfer && (win_addr != '0);
      if (xfer) begin
        WriteRegister <= win_addr;
        WriteData     <= win_data;
      end
    end
  end

  // A reservation is refused while the target is still pending; r0 never is.
  assign rsv_ready = ~busy_mask[rsv_addr];
  assign rsv_fire  = rsv_valid && rsv_ready && (rsv_addr != '0);

  // Scoreboard update: clear on writeback, then set on reservation so that
  // a same-edge reservation of the register being written survives.
  always_comb begin
    busy_nxt = busy_mask;
    if (xfer)     busy_nxt[win_addr] = 1'b0;
    if (rsv_fire) busy_nxt[rsv_addr] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      busy_mask <= '0;
    end else begin
      busy_mask <= busy_nxt;
    end
  end

  // Hazard lookups see registered state only.
  assign chk_busy1 = busy_mask[chk_addr1];
  assign chk_busy2 = busy_mask[chk_addr2];

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: a table of hand-computed vectors
// applied one per cycle, then reset-mid-write and round-robin sequences.
module tb_regfile_write_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 4;

  logic        clock;
  logic        reset_n;
  logic        rsv_valid;
  logic [3:0]  rsv_addr;
  logic        rsv_ready;
  logic [3:0]  chk_addr1;
  logic [3:0]  chk_addr2;
  logic        chk_busy1;
  logic        chk_busy2;
  logic [15:0] busy_mask;
  logic        RegWrite;
  logic [3:0]  WriteRegister;
  logic [31:0] WriteData;

  int errors = 0;
  int checks = 0;

  regfile_write_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  regfile_write_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .bus           (bus),
    .rsv_valid     (rsv_valid),
    .rsv_addr      (rsv_addr),
    .rsv_ready     (rsv_ready),
    .chk_addr1     (chk_addr1),
    .chk_addr2     (chk_addr2),
    .chk_busy1     (chk_busy1),
    .chk_busy2     (chk_busy2),
    .busy_mask     (busy_mask),
    .RegWrite      (RegWrite),
    .WriteRegister (WriteRegister),
    .WriteData     (WriteData)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    logic [3:0]  valid;
    logic [15:0] addr;
    logic [31:0] seed;     // requester i sends seed + i
    logic        rsv_v;
    logic [3:0]  rsv_a;
    logic [3:0]  c1;
    logic [3:0]  c2;
    logic [3:0]  e_ready;  // before the edge
    logic        e_rsv;
    logic        e_b1;
    logic        e_b2;
    logic [15:0] e_mask;
    logic        e_we;     // after the edge
    logic [3:0]  e_wr;
    logic [31:0] e_wd;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] valid, input logic [15:0] addr, input logic [31:0] seed,
                       input logic rv, input logic [3:0] ra, input logic [3:0] c1, input logic [3:0] c2);
    bus.req_valid = valid;
    bus.req_addr  = addr;
    for (int i = 0; i < NUM_REQ; i++) bus.req_data[i*32 +: 32] = seed + 32'(i);
    rsv_valid = rv;
    rsv_addr  = ra;
    chk_addr1 = c1;
    chk_addr2 = c2;
  endtask

  initial begin
    // addr packs requester i at [i*4 +: 4]
    vecs[0]  = '{4'b0000, 16'h0000, 32'h0,        1'b0, 4'd0, 4'd0, 4'd0, 4'b0000, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 4'd0,  32'h0};
    vecs[1]  = '{4'b0100, 16'h0500, 32'hDEADBEED, 1'b0, 4'd0, 4'd0, 4'd0, 4'b0100, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 4'd5,  32'hDEADBEEF};
    vecs[2]  = '{4'b0000, 16'h0500, 32'hDEADBEED, 1'b0, 4'd0, 4'd0, 4'd0, 4'b0000, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 4'd5,  32'hDEADBEEF};
    vecs[3]  = '{4'b0000, 16'h0000, 32'h0,        1'b1, 4'd7, 4'd7, 4'd0, 4'b0000, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 4'd5,  32'hDEADBEEF};
    vecs[4]  = '{4'b0000, 16'h0000, 32'h0,        1'b1, 4'd7, 4'd7, 4'd3, 4'b0000, 1'b0, 1'b1, 1'b0, 16'h0080, 1'b0, 4'd5,  32'hDEADBEEF};
    vecs[5]  = '{4'b0010, 16'h0070, 32'h100,      1'b0, 4'd0, 4'd7, 4'd0, 4'b0010, 1'b1, 1'b1, 1'b0, 16'h0080, 1'b1, 4'd7,  32'h101};
    vecs[6]  = '{4'b0000, 16'h0000, 32'h0,        1'b0, 4'd0, 4'd7, 4'd0, 4'b0000, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 4'd7,  32'h101};
    vecs[7]  = '{4'b0001, 16'h0000, 32'h1234,     1'b1, 4'd0, 4'd0, 4'd0, 4'b0001, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 4'd0,  32'h1234};
    vecs[8]  = '{4'b0000, 16'h0000, 32'h0,        1'b0, 4'd0, 4'd0, 4'd0, 4'b0000, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 4'd0,  32'h1234};
    vecs[9]  = '{4'b1000, 16'h3000, 32'h3000,     1'b1, 4'd3, 4'd0, 4'd0, 4'b1000, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 4'd3,  32'h3003};
    vecs[10] = '{4'b0000, 16'h0000, 32'h0,        1'b0, 4'd3, 4'd3, 4'd7, 4'b0000, 1'b0, 1'b1, 1'b0, 16'h0008, 1'b0, 4'd3,  32'h3003};
    vecs[11] = '{4'b0101, 16'h0A09, 32'h50,       1'b0, 4'd0, 4'd0, 4'd0, 4'b0001, 1'b1, 1'b0, 1'b0, 16'h0008, 1'b1, 4'd9,  32'h50};
    vecs[12] = '{4'b0101, 16'h0A09, 32'h50,       1'b0, 4'd0, 4'd0, 4'd0, 4'b0100, 1'b1, 1'b0, 1'b0, 16'h0008, 1'b1, 4'd10, 32'h52};
    vecs[13] = '{4'b0101, 16'h0A09, 32'h50,       1'b0, 4'd0, 4'd0, 4'd0, 4'b0001, 1'b1, 1'b0, 1'b0, 16'h0008, 1'b1, 4'd9,  32'h50};
    vecs[14] = '{4'b0010, 16'h0030, 32'h60,       1'b0, 4'd0, 4'd3, 4'd0, 4'b0010, 1'b1, 1'b1, 1'b0, 16'h0008, 1'b1, 4'd3,  32'h61};
    vecs[15] = '{4'b0000, 16'h0000, 32'h0,        1'b0, 4'd3, 4'd3, 4'd0, 4'b0000, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 4'd3,  32'h61};

    reset_n = 1'b0;
    drive(4'b0000, 16'h0000, 32'h0, 1'b0, 4'd0, 4'd0, 4'd0);
    #1;
    check("rst_regwrite", 32'(RegWrite), 32'd0);
    check("rst_wreg", 32'(WriteRegister), 32'd0);
    check("rst_wdata", WriteData, 32'd0);
    check("rst_busy_mask", 32'(busy_mask), 32'd0);
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check("rst_rsv_ready", 32'(rsv_ready), 32'd1);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;

    // Table: inputs at negedge, combinational checks, edge, registered checks.
    for (int v = 0; v < 16; v++) begin
      @(negedge clock);
      drive(vecs[v].valid, vecs[v].addr, vecs[v].seed, vecs[v].rsv_v, vecs[v].rsv_a, vecs[v].c1, vecs[v].c2);
      #1;
      check($sformatf("v%0d_req_ready", v), 32'(bus.req_ready), 32'(vecs[v].e_ready));
      check($sformatf("v%0d_rsv_ready", v), 32'(rsv_ready), 32'(vecs[v].e_rsv));
      check($sformatf("v%0d_chk_busy1", v), 32'(chk_busy1), 32'(vecs[v].e_b1));
      check($sformatf("v%0d_chk_busy2", v), 32'(chk_busy2), 32'(vecs[v].e_b2));
      check($sformatf("v%0d_busy_mask", v), 32'(busy_mask), 32'(vecs[v].e_mask));
      @(posedge clock);
      #1;
      check($sformatf("v%0d_regwrite", v), 32'(RegWrite), 32'(vecs[v].e_we));
      check($sformatf("v%0d_wreg", v), 32'(WriteRegister), 32'(vecs[v].e_wr));
      check($sformatf("v%0d_wdata", v), WriteData, vecs[v].e_wd);
    end

    // Reset asserted while a write is on the bank port, with r5 reserved.
    @(negedge clock);
    drive(4'b0100, 16'h0500, 32'hA0, 1'b1, 4'd5, 4'd5, 4'd0);
    #1;
    check("mid_req_ready", 32'(bus.req_ready), 32'h4);
    @(posedge clock);
    #1;
    check("mid_regwrite_pre", 32'(RegWrite), 32'd1);
    check("mid_wdata_pre", WriteData, 32'hA2);
    check("mid_busy_pre", 32'(busy_mask), 32'h0020);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_regwrite_rst", 32'(RegWrite), 32'd0);
    check("mid_wreg_rst", 32'(WriteRegister), 32'd0);
    check("mid_wdata_rst", WriteData, 32'd0);
    check("mid_busy_rst", 32'(busy_mask), 32'd0);
    drive(4'b0000, 16'h0000, 32'h0, 1'b0, 4'd0, 4'd0, 4'd0);
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    check("post_rst_ready", 32'(bus.req_ready), 32'd0);

    // All four requesters held valid for 8 cycles from rr_ptr=0.
    @(negedge clock);
    drive(4'b1111, 16'h4321, 32'h700, 1'b0, 4'd0, 4'd0, 4'd0);
    for (int k = 0; k < 8; k++) begin
      #1;
      check($sformatf("rr%0d_grant", k), 32'(bus.req_ready), 32'd1 << (k % 4));
      @(posedge clock);
      #1;
      check($sformatf("rr%0d_regwrite", k), 32'(RegWrite), 32'd1);
      check($sformatf("rr%0d_wreg", k), 32'(WriteRegister), 32'((k % 4) + 1));
      check($sformatf("rr%0d_wdata", k), WriteData, 32'h700 + 32'(k % 4));
      @(negedge clock);
    end
    drive(4'b0000, 16'h0000, 32'h0, 1'b0, 4'd0, 4'd0, 4'd0);
    @(posedge clock);
    #1;
    check("rr_idle_regwrite", 32'(RegWrite), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
